// File: rtl/tinyalu_ctrl_pkg.sv
// Shared types and constants for the tinyalu arbiter slice.
package tinyalu_ctrl_pkg;

  // Controller states: pick a requester, run the ALU, recover from a hang, answer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_e;

  // ALU opcodes; any opcode with bit 2 set goes to the multiplier.
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  // A NOP is answered locally and never reaches the ALU.
  function automatic logic op_is_nop(input logic [2:0] op);
    return (op == OP_NOP);
  endfunction

endpackage

// File: rtl/tinyalu_arbiter_rr.sv
// Combinational round-robin picker: first valid requester after last_grant.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  // Scan requesters starting one past the previous winner, wrapping around.
  always_comb begin
    int cand;
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_grant) + i) % N;
      if (!grant_valid && req[cand]) begin
        grant_valid    = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = IW'(cand);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one tinyalu among NUM_REQ requesters, one operation at a time,
// with a done-timeout that flushes the ALU and returns an error response.
module tinyalu_arbiter
  import tinyalu_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 8,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_error,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  output logic                 alu_reset_n,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e               state_r, state_s;
  logic                 accept_s;
  logic [NUM_REQ-1:0]   grant_oh_s;
  logic [IW-1:0]        grant_idx_s;
  logic                 grant_valid_s;
  logic [7:0]           sel_a_s, sel_b_s;
  logic [2:0]           sel_op_s;
  logic [IW-1:0]        last_grant_r, id_r;
  logic [CW-1:0]        busy_cnt_r;
  logic                 flush_r, alu_start_r, rsp_valid_r, rsp_error_r;
  logic [2:0]           alu_op_r;
  logic [7:0]           alu_a_r, alu_b_r;
  logic [IW-1:0]        rsp_id_r;
  logic [15:0]          rsp_result_r;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req         (req_valid),
    .last_grant  (last_grant_r),
    .grant_oh    (grant_oh_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Pick the granted requester's operands out of the packed buses.
  always_comb begin
    sel_a_s  = 8'd0;
    sel_b_s  = 8'd0;
    sel_op_s = OP_NOP;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh_s[i]) begin
        sel_a_s  = req_a[8*i +: 8];
        sel_b_s  = req_b[8*i +: 8];
        sel_op_s = req_op[3*i +: 3];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // Next-state decode; the accept happens combinationally in IDLE only.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (reset_n && grant_valid_s) begin
          accept_s = 1'b1;
          state_s  = op_is_nop(sel_op_s) ? RESP : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (alu_done) begin
          state_s = RESP;
        end else if (busy_cnt_r == CW'(TIMEOUT - 1)) begin
          state_s = FLUSH;
        end else begin
          state_s = BUSY;
        end
      end
      FLUSH: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant pointer, operand latches, busy counter, ALU drive and response registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_r <= IW'(NUM_REQ - 1);
      id_r         <= '0;
      busy_cnt_r   <= '0;
      flush_r      <= 1'b0;
      alu_start_r  <= 1'b0;
      alu_op_r     <= OP_NOP;
      alu_a_r      <= 8'd0;
      alu_b_r      <= 8'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= 16'd0;
      rsp_error_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        last_grant_r <= grant_idx_s;
        id_r         <= grant_idx_s;
        busy_cnt_r   <= '0;
        // Operands only move when the ALU will actually be started.
        if (!op_is_nop(sel_op_s)) begin
          alu_a_r <= sel_a_s;
          alu_b_r <= sel_b_s;
        end
      end else if (state_r == BUSY) begin
        busy_cnt_r <= busy_cnt_r + CW'(1);
      end
      alu_start_r <= (state_s == BUSY);
      alu_op_r    <= (state_s == BUSY) ? (accept_s ? sel_op_s : alu_op_r) : OP_NOP;
      flush_r     <= (state_s == FLUSH);
      if (state_s == RESP && state_r != RESP) begin
        rsp_valid_r  <= 1'b1;
        rsp_id_r     <= accept_s ? grant_idx_s : id_r;
        rsp_result_r <= (state_r == BUSY) ? alu_result : 16'd0;
        rsp_error_r  <= (state_r == FLUSH);
      end else if (state_r == RESP && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign req_ready   = accept_s ? grant_oh_s : '0;
  assign alu_reset_n = reset_n & ~flush_r;
  assign alu_start   = alu_start_r;
  assign alu_op      = alu_op_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_id      = rsp_id_r;
  assign rsp_result  = rsp_result_r;
  assign rsp_error   = rsp_error_r;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a small behavioural ALU model.
module tb_tinyalu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [11:0] req_op;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result, alu_result;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start, alu_reset_n, alu_done;
  logic        hang, stray_done, mdl_done;
  logic [1:0]  mcnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_reset_n(alu_reset_n), .alu_done(alu_done),
    .alu_result(alu_result)
  );

  // ALU model: single-cycle ops finish one edge after start, MUL after four.
  always @(posedge clk) begin
    if (!alu_reset_n) begin
      mdl_done <= 1'b0;
      mcnt     <= 2'd0;
    end else if (alu_start && !mdl_done && !hang && alu_op != 3'd0) begin
      if (!alu_op[2]) mdl_done <= 1'b1;
      else if (mcnt == 2'd3) mdl_done <= 1'b1;
      else mcnt <= mcnt + 2'd1;
    end else begin
      mdl_done <= 1'b0;
      mcnt     <= 2'd0;
    end
  end

  assign alu_done = mdl_done | stray_done;

  // ALU model result path.
  always_comb begin
    case (alu_op)
      3'd1:    alu_result = {8'd0, alu_a} + {8'd0, alu_b};
      3'd2:    alu_result = {8'd0, alu_a & alu_b};
      3'd3:    alu_result = {8'd0, alu_a ^ alu_b};
      3'd0:    alu_result = 16'd0;
      default: alu_result = {8'd0, alu_a} * {8'd0, alu_b};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_op[3*i +: 3] = op;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_id;
    reset_n = 1'b0; req_valid = 4'd0; req_a = 32'd0; req_b = 32'd0; req_op = 12'd0;
    rsp_ready = 1'b1; hang = 1'b0; stray_done = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_id", rsp_id, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_error", rsp_error, 32'd0);
    chk("rst_alu_start", alu_start, 32'd0);
    chk("rst_alu_op", alu_op, 32'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    chk("rst_alu_reset_n", alu_reset_n, 32'd0);
    reset_n = 1'b1;
    tick();

    // All four requesters hold XOR requests: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_req(i, 8'hF0, 8'h0F, 3'd3);
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      chk("xor_grant", req_ready, 32'd1 << exp_id);
      tick();
      if (k == 4) req_valid = 4'd0;
      tick();
      chk("xor_no_accept_busy", req_ready, 32'd0);
      tick();
      chk("xor_rsp_valid", rsp_valid, 32'd1);
      chk("xor_rsp_id", rsp_id, exp_id);
      chk("xor_result", rsp_result, 32'd255);
      tick();
    end

    // ADD from requester 2: 200 + 100.
    set_req(2, 8'd200, 8'd100, 3'd1);
    req_valid = 4'b0100;
    #1;
    chk("add_ready", req_ready, 32'h4);
    tick();
    req_valid = 4'd0;
    chk("add_start_c1", alu_start, 32'd1);
    chk("add_operands", {13'd0, alu_op, alu_a, alu_b}, {13'd0, 3'd1, 8'd200, 8'd100});
    tick();
    chk("add_no_rsp_c2", rsp_valid, 32'd0);
    tick();
    chk("add_rsp_valid_c3", rsp_valid, 32'd1);
    chk("add_rsp_id", rsp_id, 32'd2);
    chk("add_result", rsp_result, 32'd300);
    chk("add_error", rsp_error, 32'd0);
    chk("add_start_low_c3", alu_start, 32'd0);
    tick();

    // MUL from requester 0: 255 * 255.
    set_req(0, 8'd255, 8'd255, 3'd4);
    req_valid = 4'b0001;
    #1;
    chk("mul_ready", req_ready, 32'h1);
    tick();
    req_valid = 4'd0;
    for (int c = 1; c <= 5; c++) begin
      chk("mul_start_high", alu_start, 32'd1);
      chk("mul_no_rsp_yet", rsp_valid, 32'd0);
      tick();
    end
    chk("mul_rsp_valid_c6", rsp_valid, 32'd1);
    chk("mul_rsp_id", rsp_id, 32'd0);
    chk("mul_result", rsp_result, 32'd65025);
    chk("mul_start_low_c6", alu_start, 32'd0);
    chk("mul_op_cleared", alu_op, 32'd0);
    tick();

    // NOP from requester 1 with rsp_ready held low for five cycles.
    set_req(1, 8'h11, 8'h22, 3'd0);
    set_req(3, 8'd5, 8'd6, 3'd0);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("nop_ready", req_ready, 32'h2);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("nop_rsp_valid_c1", rsp_valid, 32'd1);
    chk("nop_rsp_id", rsp_id, 32'd1);
    chk("nop_result", rsp_result, 32'd0);
    chk("nop_error", rsp_error, 32'd0);
    chk("nop_no_start", alu_start, 32'd0);
    chk("nop_alu_a_held", alu_a, 32'hFF);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_rsp_valid", rsp_valid, 32'd1);
      chk("hold_rsp_fields", {rsp_error, rsp_id, rsp_result}, {13'd0, 1'b0, 2'd1, 16'd0});
      chk("hold_no_accept", req_ready, 32'd0);
      chk("hold_no_start", alu_start, 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 4'd0;
    tick();
    chk("hold_released", rsp_valid, 32'd0);

    // alu_done outside BUSY must be ignored.
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    chk("stray_done_no_rsp", rsp_valid, 32'd0);
    chk("stray_done_no_start", alu_start, 32'd0);

    // ALU never answers: TIMEOUT busy cycles, one flush cycle, error response.
    hang = 1'b1;
    set_req(1, 8'd3, 8'd4, 3'd1);
    req_valid = 4'b0010;
    #1;
    chk("to_ready", req_ready, 32'h2);
    tick();
    req_valid = 4'd0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      chk("to_busy_alu_reset_n", alu_reset_n, 32'd1);
      chk("to_busy_start", alu_start, 32'd1);
      tick();
    end
    chk("to_flush_alu_reset_n", alu_reset_n, 32'd0);
    chk("to_flush_start", alu_start, 32'd0);
    chk("to_flush_no_rsp", rsp_valid, 32'd0);
    tick();
    chk("to_after_flush_alu_reset_n", alu_reset_n, 32'd1);
    chk("to_rsp_valid", rsp_valid, 32'd1);
    chk("to_rsp_error", rsp_error, 32'd1);
    chk("to_rsp_result", rsp_result, 32'd0);
    chk("to_rsp_id", rsp_id, 32'd1);
    hang = 1'b0;
    tick();

    // Recovery: ADD 3 + 4 after the flush.
    req_valid = 4'b0010;
    #1;
    chk("rec_ready", req_ready, 32'h2);
    tick();
    req_valid = 4'd0;
    tick();
    tick();
    chk("rec_rsp_valid", rsp_valid, 32'd1);
    chk("rec_result", rsp_result, 32'd7);
    chk("rec_error", rsp_error, 32'd0);
    tick();

    // Reset during a MUL's BUSY phase: no response, everything back to reset values.
    set_req(0, 8'd255, 8'd255, 3'd4);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = 4'd0;
    tick();
    chk("mrst_busy_start", alu_start, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst_alu_reset_n_low", alu_reset_n, 32'd0);
    tick();
    chk("mrst_rsp_valid", rsp_valid, 32'd0);
    chk("mrst_alu_start", alu_start, 32'd0);
    chk("mrst_alu_op", alu_op, 32'd0);
    chk("mrst_alu_ab", {alu_a, alu_b}, 32'd0);
    chk("mrst_rsp_fields", {rsp_error, rsp_id, rsp_result}, 32'd0);
    chk("mrst_req_ready", req_ready, 32'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    chk("mrst_no_late_rsp", rsp_valid, 32'd0);
    req_valid = 4'b0011;
    #1;
    chk("mrst_ptr_reset", req_ready, 32'h1);
    req_valid = 4'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
